// File: rtl/ring_slot_scheduler_pkg.sv
// Shared definitions for the ring slot scheduler.
//   - state_e        : two-bit FSM encoding (StIdle / StGrant)
//   - DefaultN       : default requester count
//   - DefaultMaxHold : default grant length limit for the optional timeout
//   - MaxN           : widest requester vector the rotate helper supports
//   - rotl1()        : rotate an n-bit one-hot vector left by one, bit n-1 wrapping to bit 0
package ring_sched_pkg;

  localparam int unsigned DefaultN       = 4;
  localparam int unsigned DefaultMaxHold = 8;
  localparam int unsigned MaxN           = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StGrant = 2'b01
  } state_e;

  // Only the low n bits of v are meaningful; the result is zero above bit n-1.
  function automatic logic [MaxN-1:0] rotl1(input logic [MaxN-1:0] v, input int unsigned n);
    logic [MaxN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (i < n) r[(i + 1) % n] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_slot_scheduler_if.sv
// Request/grant bundle between requesters and the ring slot scheduler.
//   master : requester side, drives enable/req/done, observes grant and pointer
//   slave  : scheduler side
// Signals: enable, req[N], done[N], grant[N], grant_valid, ptr[N], ptr_bar[N], timeout.
interface ring_slot_scheduler_if #(
  parameter int unsigned N = ring_sched_pkg::DefaultN
) ();

  logic         enable;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [N-1:0] ptr;
  logic [N-1:0] ptr_bar;
  logic         timeout;

  modport master (
    output enable, req, done,
    input  grant, grant_valid, ptr, ptr_bar, timeout
  );

  modport slave (
    input  enable, req, done,
    output grant, grant_valid, ptr, ptr_bar, timeout
  );

endinterface

// File: rtl/ring_rr_pick.sv
// Combinational round-robin pick.
//   req  : request vector
//   ptr  : one-hot highest-priority position
//   pick : one-hot first request at or above ptr, wrapping; zero when req is zero
module ring_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] pick
);

  logic [N-1:0]   at_or_above;
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] lowest;

  // ptr - 1 sets every bit below the pointer; its inverse keeps ptr and above.
  assign at_or_above = req & ~(ptr - {{(N-1){1'b0}}, 1'b1});
  // Lower half holds the non-wrapped candidates, upper half the wrapped ones,
  // so isolating the lowest set bit gives the round-robin winner.
  assign dbl    = {req, at_or_above};
  assign lowest = dbl & (~dbl + {{(2*N-1){1'b0}}, 1'b1});
  assign pick   = lowest[N-1:0] | lowest[2*N-1:N];

endmodule

// File: rtl/ring_slot_scheduler.sv
// Round-robin scheduler sharing one resource among N requesters.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : slave side of ring_slot_scheduler_if (enable/req/done in,
//                grant/grant_valid/ptr/ptr_bar/timeout out)
// Optional macro RING_SCHED_TIMEOUT_EN: force release after MAX_HOLD grant
// cycles and pulse timeout; when undefined, timeout is tied low.
module ring_slot_scheduler
  import ring_sched_pkg::*;
#(
  parameter int unsigned N        = DefaultN,
  parameter int unsigned MAX_HOLD = DefaultMaxHold
) (
  input logic                  clk,
  input logic                  reset,
  ring_slot_scheduler_if.slave bus
);

  if (N < 2 || N > MaxN) begin : g_bad_n
    $error("ring_slot_scheduler: N out of range");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("ring_slot_scheduler: MAX_HOLD must be at least 1");
  end

  state_e       state_q, state_d;
  logic [N-1:0] grant_q, grant_d;
  logic [N-1:0] ptr_q, ptr_d;
  logic [N-1:0] pick;
  logic         release_req;

  ring_rr_pick #(.N(N)) u_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick)
  );

  // Owner finishes or withdraws; other requesters' done/req are ignored here.
  assign release_req = (state_q == StGrant) &&
                       ((|(grant_q & bus.done)) || !(|(grant_q & bus.req)));

`ifdef RING_SCHED_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD) + 1;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
`ifdef RING_SCHED_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.enable && (|bus.req)) begin
          grant_d = pick;
          state_d = StGrant;
`ifdef RING_SCHED_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      StGrant: begin
        if (release_req) begin
          grant_d = '0;
          state_d = StIdle;
          ptr_d   = N'(rotl1(MaxN'(grant_q), N));
        end
`ifdef RING_SCHED_TIMEOUT_EN
        else if (hold_q == HoldW'(MAX_HOLD - 1)) begin
          grant_d   = '0;
          state_d   = StIdle;
          ptr_d     = N'(rotl1(MaxN'(grant_q), N));
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
`endif
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= {{(N-1){1'b0}}, 1'b1};
`ifdef RING_SCHED_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
`ifdef RING_SCHED_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.ptr         = ptr_q;
  assign bus.ptr_bar     = ~ptr_q;
`ifdef RING_SCHED_TIMEOUT_EN
  assign bus.timeout     = timeout_q;
`else
  assign bus.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_ring_slot_scheduler.sv
// Scoreboard bench for ring_slot_scheduler: the driver applies directed and
// random stimulus, a reference model tracks owner/pointer as integer indices
// and queues the expected outputs; a monitor pops and compares each cycle.
module tb_ring_slot_scheduler;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ring_slot_scheduler_if #(.N(N)) bus ();

  ring_slot_scheduler #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [N-1:0] grant;
    logic [N-1:0] ptr;
    logic         timeout;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: owner index (-1 = idle), priority index, cycles held.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_hold  = 0;
  bit   m_tout  = 1'b0;

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  // Advance the model by one clock edge with the inputs that edge samples.
  task automatic model_edge(input bit rst, input bit en, input logic [N-1:0] rq,
                            input logic [N-1:0] dn);
    exp_t e;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_tout  = 1'b0;
    end else begin
      m_tout = 1'b0;
      if (m_owner < 0) begin
        if (en && rq != '0) begin
          for (int k = 0; k < N; k++) begin
            if (rq[(m_ptr + k) % N]) begin
              m_owner = (m_ptr + k) % N;
              break;
            end
          end
          m_hold = 0;
        end
      end else if (dn[m_owner] || !rq[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
`ifdef RING_SCHED_TIMEOUT_EN
        if (m_hold == MAX_HOLD - 1) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_tout  = 1'b1;
        end else begin
          m_hold++;
        end
`endif
      end
    end
    e.grant   = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    e.ptr     = N'(1) << m_ptr;
    e.timeout = m_tout;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit rst, input bit en, input logic [N-1:0] rq,
                      input logic [N-1:0] dn);
    @(negedge clk);
    #1;
    reset      = rst;
    bus.enable = en;
    bus.req    = rq;
    bus.done   = dn;
    model_edge(rst, en, rq, dn);
  endtask

  // Monitor: the expectation queued before an edge is checked at the next negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant", bus.grant, e.grant);
        check("grant_valid", N'(bus.grant_valid), N'(|e.grant));
        check("ptr", bus.ptr, e.ptr);
        check("ptr_bar", bus.ptr_bar, ~e.ptr);
        check("timeout", N'(bus.timeout), N'(e.timeout));
      end
    end
  end

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] dn;
    bit           en;
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.req    = '0;
    bus.done   = '0;

    // Reset for two cycles, then release.
    step(1, 0, '0, '0);
    step(1, 0, '0, '0);
    step(0, 0, '0, '0);

    // Single request, done pulse three cycles after grant.
    step(0, 1, 4'b0100, '0);
    step(0, 1, 4'b0100, '0);
    step(0, 1, 4'b0100, '0);
    step(0, 1, 4'b0100, '0);
    step(0, 1, 4'b0100, 4'b0100);
    step(0, 1, '0, '0);

    // Back to ptr=0001 via reset, then all requesting: done pulsed in each grant's first cycle.
    step(1, 0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 4'b1111, (m_owner < 0) ? '0 : (N'(1) << m_owner));
    end

    // Wrap from ptr=1000 to requester 0, then enable low blocks new grants.
    step(1, 0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 4'b1111, (m_owner < 0) ? '0 : (N'(1) << m_owner));
    end
    step(0, 1, 4'b0011, '0);
    step(0, 1, 4'b0011, 4'b0001);
    for (int i = 0; i < 4; i++) step(0, 0, 4'b0011, '0);

    // Long hold with no done: timeout build releases after MAX_HOLD cycles.
    step(0, 0, '0, '0);
    for (int i = 0; i < 22; i++) step(0, 1, 4'b0010, '0);
    step(0, 1, '0, '0);

    // Reset mid-grant, then the same request is re-granted.
    step(1, 0, '0, '0);
    step(0, 1, 4'b0100, '0);
    step(0, 1, 4'b0100, '0);
    step(1, 1, 4'b0100, '0);
    step(0, 1, 4'b0100, '0);
    step(0, 1, 4'b0100, '0);
    step(0, 1, 4'b0100, 4'b0100);

    // Random traffic: drifting request levels, stray and owner done pulses.
    rq = '0;
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(9) == 0) rq[b] = ~rq[b];
      end
      dn = '0;
      if ($urandom_range(3) == 0) dn[$urandom_range(N - 1)] = 1'b1;
      if (m_owner >= 0 && $urandom_range(4) == 0) dn[m_owner] = 1'b1;
      en = ($urandom_range(7) != 0);
      step(($urandom_range(99) == 0), en, rq, dn);
    end

    step(0, 0, '0, '0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d queued want 0", exp_q.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ring_slot_scheduler.md
Name: ring_slot_scheduler

Overview:
- Round-robin scheduler that shares one resource among N requesters.
- A one-hot rotating priority pointer, ring-counter style, selects the next owner.
- Grant is held until the owner signals done or drops its request.
- Sits in front of any shared datapath. It exposes ptr/ptr_bar in the same q/qbar style as the team's ring counters, for debug and for slot-indexed logic.

Parameters:
- N, 4, number of requesters (≥2).
- MAX_HOLD, 8, maximum grant length in cycles. Used only with the optional timeout; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  permits new grants; never affects a grant already issued.
- req  in  N  request per requester; level, held until served.
- done  in  N  one-cycle completion pulse from the current owner.
- grant  out  N  registered one-hot grant; all-zero when idle.
- grant_valid  out  1  equals |grant.
- ptr  out  N  one-hot priority pointer; bit i set means requester i has highest priority.
- ptr_bar  out  N  always ~ptr.
- timeout  out  1  one-cycle pulse on forced release (optional feature).

Behaviour:
- Reset (sampled on rising clk with reset=1):
  - ptr=1 (bit0), ptr_bar=~1, grant=0, grant_valid=0, timeout=0, state=IDLE, hold counter=0.
  - Reset wins over every other input, including mid-grant: grant drops at that edge.
- States: IDLE, GRANT. Two-bit encoding from the package.
- IDLE:
  - If enable=1 and req!=0: pick the first set req bit scanning upward from the ptr position, inclusive, wrapping N-1→0.
  - Next edge: grant=that one-hot, state=GRANT. Latency is exactly 1 cycle from sampled req to grant.
  - ptr is unchanged in IDLE.
  - If enable=0 or req=0: stay in IDLE, outputs hold.
- GRANT (owner g):
  - Release when done[g]=1 or req[g]=0 is sampled.
  - At the release edge: grant=0, state=IDLE, ptr=grant rotated left by 1 (bit N-1 wraps to bit 0).
  - Otherwise hold grant and ptr.
- Turnaround: at least one IDLE cycle between consecutive grants. The earliest re-grant is 2 edges after the release sample.
- Ignored inputs:
  - done bits of non-owners, and done while in IDLE.
  - req changes of non-owners while in GRANT.
- Simultaneous done[g] and req changes: release happens first; re-arbitration in IDLE uses the updated req and the new ptr.
- Invariants: grant is always one-hot or zero; ptr is always exactly one-hot.

Optional Feature:
- Macro: RING_SCHED_TIMEOUT_EN.
- Enabled:
  - Hold counter (width clog2(MAX_HOLD)+1) clears on grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 with no release condition, the next edge forces release: grant=0, ptr rotates past g, timeout=1 for exactly one cycle.
  - Result: grant is high for exactly MAX_HOLD cycles.
  - A normal release in the same cycle wins; no timeout pulse.
- Disabled: no counter logic; timeout is tied to 0; grant is held indefinitely.

Decomposition:
- Package ring_sched_pkg holds:
  - state encoding constants IDLE/GRANT;
  - default N and MAX_HOLD;
  - a rotate-left-by-one function for N-bit one-hot vectors.
- Sub-module ring_rr_pick: purely combinational.
  - Inputs: req[N], ptr[N]. Output: one-hot pick[N], zero if req=0.
  - Implemented as a double-width rotate-and-mask priority scan.
- The top module keeps the FSM, registers and the optional counter.

Test Plan:
1. Reset for 2 cycles, then release → ptr=0001, ptr_bar=1110, grant=0000, grant_valid=0, timeout=0.
2. From reset: enable=1, req=0100 → grant=0100 at the next edge. Pulse done[2] 3 cycles later → grant=0000 at the following edge, ptr=1000.
3. req=1111 held; pulse done on each owner one cycle after its grant → grants 0001,0010,0100,1000,0001, each separated by one idle cycle.
4. Wrap: after ptr=1000, req=0011 → grant=0001. enable=0 with req=0011 → grant stays 0000.
5. With RING_SCHED_TIMEOUT_EN, MAX_HOLD=8, req=0010, no done → grant=0010 for exactly 8 cycles, then grant=0000, timeout=1 for one cycle, ptr=0100. Without the macro → grant still 0010 after 20 cycles and timeout stays 0.
6. While grant=0100, assert reset for one cycle → at that edge grant=0000 and ptr=0001. After reset deasserts with req=0100 still high → grant=0100 again one cycle later.
